// File: rtl/axim_ctrl_multi_counter.sv
// axim_ctrl_multi_counter: bank of independent up/down counters with saturate or wrap,
// registered status flags and sticky overflow/underflow per channel.
module axim_ctrl_multi_counter #(
    parameter int                 C_CHANNELS = 4,
    parameter int                 C_WIDTH    = 8,
    parameter int                 C_STEP_W   = 4,
    parameter logic [C_WIDTH-1:0] C_INIT     = '0,
    parameter bit                 C_SATURATE = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clken,
    input  logic [C_CHANNELS-1:0]         load,
    input  logic [C_CHANNELS*C_WIDTH-1:0] load_value,
    input  logic [C_CHANNELS-1:0]         incr,
    input  logic [C_CHANNELS*C_STEP_W-1:0] incr_amt,
    input  logic [C_CHANNELS-1:0]         decr,
    input  logic [C_CHANNELS*C_STEP_W-1:0] decr_amt,
    input  logic [C_CHANNELS*C_WIDTH-1:0] threshold,
    input  logic [C_CHANNELS-1:0]         err_clr,
    output logic [C_CHANNELS*C_WIDTH-1:0] count,
    output logic [C_CHANNELS-1:0]         is_zero,
    output logic [C_CHANNELS-1:0]         is_max,
    output logic [C_CHANNELS-1:0]         at_thresh,
    output logic [C_CHANNELS-1:0]         ovf,
    output logic [C_CHANNELS-1:0]         udf,
    output logic                          all_zero
);
    localparam int SW = C_WIDTH + 2;

    logic [SW-1:0]      sum [C_CHANNELS];
    logic [C_WIDTH-1:0] nxt [C_CHANNELS];
    logic [C_CHANNELS-1:0] of, uf, zn;

    // Two guard bits: the top one is the sign (underflow), the next one flags overflow.
    always_comb begin
        for (int i = 0; i < C_CHANNELS; i++) begin
            sum[i] = SW'(count[i*C_WIDTH +: C_WIDTH])
                   + (incr[i] ? SW'(incr_amt[i*C_STEP_W +: C_STEP_W]) : SW'(0))
                   - (decr[i] ? SW'(decr_amt[i*C_STEP_W +: C_STEP_W]) : SW'(0));
            uf[i]  = sum[i][SW-1];
            of[i]  = ~sum[i][SW-1] & sum[i][SW-2];
            nxt[i] = load[i] ? load_value[i*C_WIDTH +: C_WIDTH] :
                     (of[i] && C_SATURATE) ? '1 :
                     (uf[i] && C_SATURATE) ? '0 : sum[i][C_WIDTH-1:0];
            zn[i]  = nxt[i] == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= {C_CHANNELS{C_INIT}};
            is_zero   <= {C_CHANNELS{C_INIT == '0}};
            is_max    <= {C_CHANNELS{&C_INIT}};
            at_thresh <= '0;
            ovf       <= '0;
            udf       <= '0;
            all_zero  <= C_INIT == '0;
        end else if (clken) begin
            for (int i = 0; i < C_CHANNELS; i++) begin
                count[i*C_WIDTH +: C_WIDTH] <= nxt[i];
                is_zero[i]   <= zn[i];
                is_max[i]    <= &nxt[i];
                at_thresh[i] <= nxt[i] >= threshold[i*C_WIDTH +: C_WIDTH];
                ovf[i]       <= ~load[i] & (of[i] | (ovf[i] & ~err_clr[i]));
                udf[i]       <= ~load[i] & (uf[i] | (udf[i] & ~err_clr[i]));
            end
            all_zero <= &zn;
        end
    end
endmodule

// File: tb/tb_axim_ctrl_multi_counter.sv
// tb_axim_ctrl_multi_counter: directed checks of a saturating and a wrapping instance
// sharing one stimulus set.
module tb_axim_ctrl_multi_counter;
    logic        clk = 1'b0;
    logic        rst, clken;
    logic [3:0]  load, incr, decr, err_clr;
    logic [7:0]  lv [4];
    logic [7:0]  th [4];
    logic [3:0]  ia [4];
    logic [3:0]  da [4];
    logic [31:0] load_value, threshold;
    logic [15:0] incr_amt, decr_amt;
    logic [31:0] count, count_w;
    logic [3:0]  is_zero, is_max, at_thresh, ovf, udf;
    logic [3:0]  is_zero_w, is_max_w, at_thresh_w, ovf_w, udf_w;
    logic        all_zero, all_zero_w;
    int          n_tests = 0;
    int          n_fail = 0;

    assign load_value = {lv[3], lv[2], lv[1], lv[0]};
    assign threshold  = {th[3], th[2], th[1], th[0]};
    assign incr_amt   = {ia[3], ia[2], ia[1], ia[0]};
    assign decr_amt   = {da[3], da[2], da[1], da[0]};

    always #5 clk = ~clk;

    axim_ctrl_multi_counter dut (
        .clk(clk), .rst(rst), .clken(clken), .load(load), .load_value(load_value),
        .incr(incr), .incr_amt(incr_amt), .decr(decr), .decr_amt(decr_amt),
        .threshold(threshold), .err_clr(err_clr), .count(count), .is_zero(is_zero),
        .is_max(is_max), .at_thresh(at_thresh), .ovf(ovf), .udf(udf), .all_zero(all_zero)
    );

    axim_ctrl_multi_counter #(.C_SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .clken(clken), .load(load), .load_value(load_value),
        .incr(incr), .incr_amt(incr_amt), .decr(decr), .decr_amt(decr_amt),
        .threshold(threshold), .err_clr(err_clr), .count(count_w), .is_zero(is_zero_w),
        .is_max(is_max_w), .at_thresh(at_thresh_w), .ovf(ovf_w), .udf(udf_w), .all_zero(all_zero_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        load = '0; incr = '0; decr = '0; err_clr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clken = 1'b1; clear_strobes();
        for (int i = 0; i < 4; i++) begin lv[i] = '0; ia[i] = '0; da[i] = '0; th[i] = 8'd200; end
        tick();
        tick();
        rst = 1'b0;
        n_tests++;
        if (count !== 32'd0) begin n_fail++; $display("FAIL reset_count got %h exp %h", count, 32'd0); end
        n_tests++;
        if ({is_zero, is_max, at_thresh, ovf, udf, all_zero} !== {4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_flags got z=%b m=%b t=%b o=%b u=%b az=%b exp z=1111 m=0000 t=0000 o=0000 u=0000 az=1",
                     is_zero, is_max, at_thresh, ovf, udf, all_zero);
        end
    endtask

    task automatic test_incr();
        incr[0] = 1'b1; ia[0] = 4'd3;
        tick();
        n_tests++;
        if (count[7:0] !== 8'd3) begin n_fail++; $display("FAIL incr_first got %0d exp 3", count[7:0]); end
        tick();
        clear_strobes();
        n_tests++;
        if (count[7:0] !== 8'd6) begin n_fail++; $display("FAIL incr_count0 got %0d exp 6", count[7:0]); end
        n_tests++;
        if ({is_zero[0], all_zero} !== 2'b00) begin n_fail++; $display("FAIL incr_zero got %b exp 00", {is_zero[0], all_zero}); end
        n_tests++;
        if (count[31:8] !== 24'd0) begin n_fail++; $display("FAIL incr_others got %h exp 0", count[31:8]); end
    endtask

    task automatic test_saturate();
        load[1] = 1'b1; lv[1] = 8'd250;
        tick();
        clear_strobes();
        n_tests++;
        if (count[15:8] !== 8'd250) begin n_fail++; $display("FAIL sat_load got %0d exp 250", count[15:8]); end
        incr[1] = 1'b1; ia[1] = 4'd10;
        tick();
        clear_strobes();
        n_tests++;
        if (count[15:8] !== 8'd255) begin n_fail++; $display("FAIL sat_count1 got %0d exp 255", count[15:8]); end
        n_tests++;
        if ({is_max[1], ovf[1], at_thresh[1], udf[1]} !== 4'b1110) begin
            n_fail++; $display("FAIL sat_flags got %b exp 1110", {is_max[1], ovf[1], at_thresh[1], udf[1]});
        end
        err_clr[1] = 1'b1;
        tick();
        clear_strobes();
        n_tests++;
        if ({ovf[1], count[15:8]} !== {1'b0, 8'd255}) begin
            n_fail++; $display("FAIL sat_errclr got ovf=%b cnt=%0d exp ovf=0 cnt=255", ovf[1], count[15:8]);
        end
        incr[1] = 1'b1; ia[1] = 4'd1; err_clr[1] = 1'b1;
        tick();
        clear_strobes();
        n_tests++;
        if (ovf[1] !== 1'b1) begin n_fail++; $display("FAIL errclr_vs_ovf got %b exp 1", ovf[1]); end
    endtask

    task automatic test_wrap();
        load[2] = 1'b1; lv[2] = 8'd2;
        tick();
        clear_strobes();
        decr[2] = 1'b1; da[2] = 4'd5;
        tick();
        clear_strobes();
        n_tests++;
        if ({count_w[23:16], udf_w[2], is_zero_w[2]} !== {8'd253, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL wrap_ch2 got cnt=%0d udf=%b z=%b exp cnt=253 udf=1 z=0", count_w[23:16], udf_w[2], is_zero_w[2]);
        end
        n_tests++;
        if ({count[23:16], udf[2], is_zero[2]} !== {8'd0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL sat_floor_ch2 got cnt=%0d udf=%b z=%b exp cnt=0 udf=1 z=1", count[23:16], udf[2], is_zero[2]);
        end
    endtask

    task automatic test_cancel();
        load[3] = 1'b1; lv[3] = 8'd7;
        tick();
        clear_strobes();
        incr[3] = 1'b1; ia[3] = 4'd4; decr[3] = 1'b1; da[3] = 4'd4;
        tick();
        clear_strobes();
        n_tests++;
        if ({count[31:24], ovf[3], udf[3]} !== {8'd7, 2'b00}) begin
            n_fail++; $display("FAIL cancel_ch3 got cnt=%0d o=%b u=%b exp cnt=7 o=0 u=0", count[31:24], ovf[3], udf[3]);
        end
        load[3] = 1'b1; lv[3] = 8'd9; incr[3] = 1'b1; ia[3] = 4'd1;
        tick();
        clear_strobes();
        n_tests++;
        if (count[31:24] !== 8'd9) begin n_fail++; $display("FAIL load_prio got %0d exp 9", count[31:24]); end
        incr[3] = 1'b1; ia[3] = 4'd0;
        tick();
        clear_strobes();
        n_tests++;
        if (count[31:24] !== 8'd9) begin n_fail++; $display("FAIL zero_amt got %0d exp 9", count[31:24]); end
    endtask

    task automatic test_thresh();
        th[0] = 8'd5; load[0] = 1'b1; lv[0] = 8'd0;
        tick();
        clear_strobes();
        incr[0] = 1'b1; ia[0] = 4'd1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_tests++;
            if ({count[7:0], at_thresh[0]} !== {8'(k), k >= 5}) begin
                n_fail++; $display("FAIL thresh_step%0d got cnt=%0d t=%b exp cnt=%0d t=%b", k, count[7:0], at_thresh[0], k, k >= 5);
            end
        end
        clear_strobes();
        th[0] = 8'd8;
        tick();
        n_tests++;
        if ({count[7:0], at_thresh[0]} !== {8'd5, 1'b0}) begin
            n_fail++; $display("FAIL thresh_raise got cnt=%0d t=%b exp cnt=5 t=0", count[7:0], at_thresh[0]);
        end
    endtask

    task automatic test_hold();
        clken = 1'b0; load = 4'hF; incr = 4'hF;
        for (int i = 0; i < 4; i++) begin lv[i] = 8'h11; ia[i] = 4'd2; end
        tick();
        n_tests++;
        if (count !== {8'd9, 8'd0, 8'd255, 8'd5}) begin n_fail++; $display("FAIL hold_count got %h exp 0900ff05", count); end
        n_tests++;
        if ({is_max, ovf, udf, is_zero, all_zero} !== {4'b0010, 4'b0010, 4'b0100, 4'b0100, 1'b0}) begin
            n_fail++; $display("FAIL hold_flags got m=%b o=%b u=%b z=%b az=%b exp m=0010 o=0010 u=0100 z=0100 az=0",
                                 is_max, ovf, udf, is_zero, all_zero);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (count !== 32'd0) begin n_fail++; $display("FAIL rst_noclken_count got %h exp 0", count); end
        n_tests++;
        if ({is_zero, ovf, udf, at_thresh, all_zero} !== {4'hF, 4'h0, 4'h0, 4'h0, 1'b1}) begin
            n_fail++; $display("FAIL rst_noclken_flags got z=%b o=%b u=%b t=%b az=%b exp z=1111 o=0000 u=0000 t=0000 az=1",
                                 is_zero, ovf, udf, at_thresh, all_zero);
        end
        clear_strobes();
        clken = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_incr();
        test_saturate();
        test_wrap();
        test_cancel();
        test_thresh();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
